// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, drives the ROM, buffers
// {pc, inst} pairs in a small queue and hands them to decode over valid/ready.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [63:0] rom_inst_pc,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        halted
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      pc;
  logic [31:0]      q_pc   [QDEPTH];
  logic [31:0]      q_inst [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // A jump suppresses both queue operations; a full queue may still push
  // when the head is leaving in the same cycle.
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready & ~jump_en;
  assign push      = (state == FETCH) & rom_ce & ~jump_en &
                     ((count < CNT_W'(QDEPTH)) | pop);

  assign rom_addr  = pc;
  assign out_pc    = q_pc[rd_ptr];
  assign out_inst  = q_inst[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      rom_ce <= 1'b0;
      halted <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else begin
      if (jump_en) begin
        pc     <= jump_addr & 32'hFFFF_FFFC;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          q_pc[wr_ptr]   <= rom_inst_pc[63:32];
          q_inst[wr_ptr] <= rom_inst_pc[31:0];
          wr_ptr         <= wr_ptr + 1'b1;
          pc             <= pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
      end

      case (state)
        IDLE: begin
          state  <= FETCH;
          rom_ce <= 1'b1;
        end
        FETCH: begin
          if (halt_req && !jump_en) begin
            state  <= HALT;
            rom_ce <= 1'b0;
            halted <= 1'b1;
          end
        end
        HALT: begin
          // A redirect while halted only retargets the PC.
          if (!halt_req && !jump_en) begin
            state  <= FETCH;
            rom_ce <= 1'b1;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          rom_ce <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: stream, backpressure, jump flush,
// halt/resume, jump-with-halt, PC wrap and mid-stream reset.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [63:0] rom_inst_pc;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce     (rom_ce),
    .rom_addr   (rom_addr),
    .rom_inst_pc(rom_inst_pc),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .halt_req   (halt_req),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // ROM word for an address: an addi-style opcode mixed with the address
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h0040_0013;
  endfunction

  assign rom_inst_pc = {rom_addr, rom_word(rom_addr)};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_pc);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_pc"}, out_pc, exp_pc);
    chk({tag, "_inst"}, out_inst, rom_word(exp_pc));
  endtask

  initial begin
    rst = 1'b1; jump_en = 1'b0; jump_addr = '0; halt_req = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_ce", {31'd0, rom_ce}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_addr", rom_addr, 32'd0);

    // c0: IDLE
    rst = 1'b0; out_ready = 1'b1;
    tick();
    chk("c1_ce", {31'd0, rom_ce}, 32'd1);
    chk("c1_addr", rom_addr, 32'd0);
    chk("c1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_head("stream", 32'(4 * i));
      chk("stream_addr", rom_addr, 32'(4 * i + 4));
      tick();
    end

    // head 0x14, one entry queued; stall decode
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_addr", rom_addr, 32'h1C);
      chk_head("bp_head", 32'h14);
      tick();
    end
    out_ready = 1'b1;
    chk_head("rel0", 32'h14);
    tick();
    chk_head("rel1", 32'h18);
    tick();
    chk_head("rel2", 32'h1C);
    chk("rel2_addr", rom_addr, 32'h24);

    // jump with two entries (0x1C, 0x20) queued
    jump_en = 1'b1; jump_addr = 32'h43;
    tick();
    jump_en = 1'b0;
    chk("jmp1_addr", rom_addr, 32'h40);
    chk("jmp1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_head("jmp2", 32'h40);
    tick();
    chk_head("jmp3", 32'h44);

    // fill the queue, then halt
    out_ready = 1'b0;
    tick();
    chk("fill_addr", rom_addr, 32'h4C);
    halt_req = 1'b1; out_ready = 1'b1;
    chk_head("h0", 32'h44);
    tick();
    chk("h1_ce", {31'd0, rom_ce}, 32'd0);
    chk("h1_halted", {31'd0, halted}, 32'd1);
    chk_head("h1", 32'h48);
    tick();
    chk_head("h2", 32'h4C);
    tick();
    chk("h3_valid", {31'd0, out_valid}, 32'd0);
    chk("h3_addr", rom_addr, 32'h50);
    tick();
    halt_req = 1'b0;
    chk("h4_halted", {31'd0, halted}, 32'd1);
    tick();
    chk("res_ce", {31'd0, rom_ce}, 32'd1);
    chk("res_halted", {31'd0, halted}, 32'd0);
    chk("res_addr", rom_addr, 32'h50);
    tick();
    chk_head("res", 32'h50);

    // jump and halt together: jump wins
    jump_en = 1'b1; jump_addr = 32'h100; halt_req = 1'b1;
    tick();
    jump_en = 1'b0; halt_req = 1'b0;
    chk("jh_ce", {31'd0, rom_ce}, 32'd1);
    chk("jh_halted", {31'd0, halted}, 32'd0);
    chk("jh_addr", rom_addr, 32'h100);
    tick();
    chk_head("jh", 32'h100);

    // jump while halted
    halt_req = 1'b1;
    tick();
    chk("hj_halted", {31'd0, halted}, 32'd1);
    jump_en = 1'b1; jump_addr = 32'h200;
    tick();
    jump_en = 1'b0; halt_req = 1'b0;
    chk("hj_still_halted", {31'd0, halted}, 32'd1);
    chk("hj_addr", rom_addr, 32'h200);
    chk("hj_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("hj_ce", {31'd0, rom_ce}, 32'd1);
    tick();
    chk_head("hj", 32'h200);

    // PC wrap
    jump_en = 1'b1; jump_addr = 32'hFFFF_FFFF;
    tick();
    jump_en = 1'b0;
    chk("wrap_addr", rom_addr, 32'hFFFF_FFFC);
    tick();
    chk_head("wrap0", 32'hFFFF_FFFC);
    chk("wrap_addr0", rom_addr, 32'h0);
    tick();
    chk_head("wrap1", 32'h0);

    // reset mid-stream
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_ce", {31'd0, rom_ce}, 32'd0);
    chk("mr_addr", rom_addr, 32'h0);
    chk("mr_pc", out_pc, 32'h0);
    tick();
    chk("mr1_ce", {31'd0, rom_ce}, 32'd1);
    chk("mr1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_head("mr2", 32'h0);
    tick();
    chk_head("mr3", 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
